game_score_controller: RTL and testbench
========================================

GAME_SCORE_CONTROLLER -- requirements
Module: game_score_controller

Interface
REQ-001 SHALL provide parameter SERVE_FRAMES, default 60, frames spent in SERVE before play resumes (range 1..255).
REQ-002 SHALL provide parameter MAX_PENDING, default 15, saturation limit of the pending-score counter (range 1..15).
REQ-003 clk  input  1  system/pixel clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  player start button, level, sampled every clk.
REQ-006 vsync  input  1  vertical sync from the sync generator, active-high.
REQ-007 brick_hit  input  1  one-clk pulse per brick destroyed.
REQ-008 ball_lost  input  1  one-clk pulse when the ball passes the paddle.
REQ-009 lives_in  input  4  current lives count read back from the stats block.
REQ-010 inscore  output  1  one-clk score-increment pulse to the stats block.
REQ-011 declives  output  1  one-clk life-decrement pulse to the stats block.
REQ-012 stats_reset  output  1  one-clk pulse to reinitialise score and lives.
REQ-013 ball_enable  output  1  high only in PLAY; gates ball motion.
REQ-014 state  output  3  FSM state encoding: ATTRACT=0, SERVE=1, PLAY=2, LOSE=3, OVER=4.
REQ-015 pending  output  4  score points awaiting transfer.
REQ-016 overflow  output  1  sticky flag: a brick_hit was dropped at saturation.

Function
REQ-017 frame_tick SHALL be an internal one-clk strobe, high in the cycle after vsync is first sampled high after having been low (registered edge detect).
REQ-018 In ATTRACT or OVER, start high SHALL in the same edge: pulse stats_reset, clear pending and overflow, load serve counter with SERVE_FRAMES, enter SERVE.
REQ-019 start SHALL be ignored in SERVE, PLAY and LOSE.
REQ-020 SERVE: each frame_tick decrements the serve counter; the frame_tick that takes it from 1 to 0 SHALL enter PLAY.
REQ-021 PLAY: brick_hit SHALL increment pending; at MAX_PENDING the increment is dropped and overflow set.
REQ-022 brick_hit SHALL be ignored outside PLAY.
REQ-023 PLAY: ball_lost SHALL enter LOSE and drive declives high for exactly the next clk.
REQ-024 ball_lost SHALL be ignored outside PLAY.
REQ-025 brick_hit and ball_lost in the same clk SHALL both take effect.
REQ-026 LOSE: at the first frame_tick, enter OVER if lives_in==0, else load the serve counter with SERVE_FRAMES and enter SERVE.
REQ-027 In any state except ATTRACT, on frame_tick with pending>0, inscore SHALL pulse for one clk and pending SHALL decrement (at most one point per frame).
REQ-028 A brick_hit coinciding with a drain SHALL leave pending unchanged.
REQ-029 Saturation SHALL be evaluated before the decrement, so a hit at MAX_PENDING coinciding with a drain is dropped and sets overflow.
REQ-030 In the clk where stats_reset pulses, inscore SHALL be suppressed and pending forced to 0.
REQ-031 inscore, declives and stats_reset SHALL be registered outputs, never wider than one clk per event.
REQ-032 inscore and declives may coincide.

Reset
REQ-033 On reset: state=ATTRACT, pending=0, overflow=0, serve counter=0, and the vsync edge register is cleared.
REQ-034 On reset: inscore, declives, stats_reset and ball_enable are all 0.
REQ-035 Reset asserted mid-game SHALL abandon all pending points without emitting inscore.
REQ-036 stats_reset SHALL NOT pulse on reset; the stats block takes the system reset directly.

Verification
REQ-037 reset, then start=1 for 1 clk -> stats_reset pulses once, state=SERVE; after exactly 60 frame_ticks -> state=PLAY, ball_enable=1.
REQ-038 In PLAY, 3 brick_hits in consecutive clks -> pending=3; the next 3 frame_ticks each give one inscore pulse; pending reaches 0, then no further inscore.
REQ-039 In PLAY, 20 brick_hits with MAX_PENDING=15 and no vsync -> pending=15, overflow=1; a hit coincident with a drain at pending=15 -> pending=14 after that clk.
REQ-040 In PLAY, ball_lost with lives_in=2 -> one declives pulse, LOSE, then SERVE at the next frame_tick; repeat with lives_in=0 -> OVER, ball_enable=0.
REQ-041 In OVER with pending=5, start -> stats_reset pulse, pending=0, no inscore that clk, overflow cleared, state=SERVE.
REQ-042 Reset asserted during PLAY with pending=7 -> all outputs 0 and state=ATTRACT immediately (asynchronous); no inscore after release.

Source files
------------

// File: rtl/game_score_controller.sv
`timescale 1ns/1ps
// game_score_controller
// Game-flow sequencer for a brick-breaker style game. Walks the game through
// ATTRACT -> SERVE -> PLAY -> LOSE -> (SERVE | OVER). It also buffers score
// points from brick hits and hands them to the stats block at one point per
// video frame.
//
// Parameters
//   SERVE_FRAMES  frames spent in SERVE before play resumes (1..255)
//   MAX_PENDING   saturation limit of the pending-score counter (1..15)
//
// Ports
//   clk          system/pixel clock, all state changes on its rising edge
//   reset        asynchronous, active-high reset
//   start        player start button (level)
//   vsync        vertical sync, active-high; its rising edge defines a frame
//   brick_hit    one-clk pulse per brick destroyed
//   ball_lost    one-clk pulse when the ball passes the paddle
//   lives_in     current lives count from the stats block
//   inscore      one-clk score-increment pulse (registered)
//   declives     one-clk life-decrement pulse (registered)
//   stats_reset  one-clk pulse to reinitialise score and lives (registered)
//   ball_enable  high only in PLAY
//   state        ATTRACT=0, SERVE=1, PLAY=2, LOSE=3, OVER=4
//   pending      score points awaiting transfer
//   overflow     sticky: a brick_hit was dropped at saturation
module game_score_controller #(
   parameter int SERVE_FRAMES = 60,
   parameter int MAX_PENDING  = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       vsync,
   input  logic       brick_hit,
   input  logic       ball_lost,
   input  logic [3:0] lives_in,
   output logic       inscore,
   output logic       declives,
   output logic       stats_reset,
   output logic       ball_enable,
   output logic [2:0] state,
   output logic [3:0] pending,
   output logic       overflow
);

   localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);
   localparam logic [3:0] PEND_MAX   = 4'(MAX_PENDING);

   typedef enum logic [2:0] {
      ST_ATTRACT = 3'd0,
      ST_SERVE   = 3'd1,
      ST_PLAY    = 3'd2,
      ST_LOSE    = 3'd3,
      ST_OVER    = 3'd4
   } state_t;

   state_t     state_reg, state_next;
   logic [7:0] serve_cnt_reg, serve_cnt_next;
   logic [3:0] pending_reg, pending_next;
   logic       overflow_reg, overflow_next;
   logic       inscore_reg, inscore_next;
   logic       declives_reg, declives_next;
   logic       stats_reset_reg, stats_reset_next;
   logic       vsync_d_reg;
   logic       frame_tick_reg;

   logic       new_game;
   logic       drain;
   logic       hit_take;
   logic       hit_drop;

   // A new game may only be started from the idle states.
   assign new_game = start && ((state_reg == ST_ATTRACT) || (state_reg == ST_OVER));

   // One point leaves per frame in every state except ATTRACT.
   assign drain = frame_tick_reg && (state_reg != ST_ATTRACT) && (pending_reg != 4'd0);

   // Saturation is judged on the pre-drain count, so a hit arriving at the
   // limit is dropped even if a drain in the same clk would have made room.
   assign hit_take = (state_reg == ST_PLAY) && brick_hit && (pending_reg <  PEND_MAX);
   assign hit_drop = (state_reg == ST_PLAY) && brick_hit && (pending_reg >= PEND_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= ST_ATTRACT;
         serve_cnt_reg   <= 8'd0;
         pending_reg     <= 4'd0;
         overflow_reg    <= 1'b0;
         inscore_reg     <= 1'b0;
         declives_reg    <= 1'b0;
         stats_reset_reg <= 1'b0;
         vsync_d_reg     <= 1'b0;
         frame_tick_reg  <= 1'b0;
      end else begin
         state_reg       <= state_next;
         serve_cnt_reg   <= serve_cnt_next;
         pending_reg     <= pending_next;
         overflow_reg    <= overflow_next;
         inscore_reg     <= inscore_next;
         declives_reg    <= declives_next;
         stats_reset_reg <= stats_reset_next;
         vsync_d_reg     <= vsync;
         // Strobe for the cycle after vsync is first seen high.
         frame_tick_reg  <= vsync && !vsync_d_reg;
      end
   end

   always_comb begin
      state_next       = state_reg;
      serve_cnt_next   = serve_cnt_reg;
      pending_next     = pending_reg;
      overflow_next    = overflow_reg;
      inscore_next     = 1'b0;
      declives_next    = 1'b0;
      stats_reset_next = 1'b0;

      if (new_game) begin
         // Points still queued from the previous game are discarded, never
         // transferred into the freshly cleared score.
         stats_reset_next = 1'b1;
         pending_next     = 4'd0;
         overflow_next    = 1'b0;
         serve_cnt_next   = SERVE_LOAD;
         state_next       = ST_SERVE;
      end else begin
         pending_next = pending_reg + {3'b000, hit_take} - {3'b000, drain};
         inscore_next = drain;
         if (hit_drop) begin
            overflow_next = 1'b1;
         end

         unique case (state_reg)
            ST_SERVE: begin
               if (frame_tick_reg) begin
                  serve_cnt_next = serve_cnt_reg - 8'd1;
                  if (serve_cnt_reg <= 8'd1) begin
                     serve_cnt_next = 8'd0;
                     state_next     = ST_PLAY;
                  end
               end
            end
            ST_PLAY: begin
               if (ball_lost) begin
                  declives_next = 1'b1;
                  state_next    = ST_LOSE;
               end
            end
            ST_LOSE: begin
               if (frame_tick_reg) begin
                  if (lives_in == 4'd0) begin
                     state_next = ST_OVER;
                  end else begin
                     serve_cnt_next = SERVE_LOAD;
                     state_next     = ST_SERVE;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign inscore     = inscore_reg;
   assign declives    = declives_reg;
   assign stats_reset = stats_reset_reg;
   assign ball_enable = (state_reg == ST_PLAY);
   assign state       = state_reg;
   assign pending     = pending_reg;
   assign overflow    = overflow_reg;

endmodule

// File: tb/tb_game_score_controller.sv
`timescale 1ns/1ps
// tb_game_score_controller
// Directed game scenarios followed by a long randomized run. A behavioural
// reference model written from the game rules predicts every output after
// each clock edge.
module tb_game_score_controller;

   localparam int SF = 60;
   localparam int MP = 15;

   localparam int S_ATTRACT = 0;
   localparam int S_SERVE   = 1;
   localparam int S_PLAY    = 2;
   localparam int S_LOSE    = 3;
   localparam int S_OVER    = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       vsync = 1'b0;
   logic       brick_hit = 1'b0;
   logic       ball_lost = 1'b0;
   logic [3:0] lives_in = 4'd3;
   logic       inscore, declives, stats_reset, ball_enable, overflow;
   logic [2:0] state;
   logic [3:0] pending;

   int total = 0;
   int bad   = 0;
   int ins_seen = 0;

   // reference model state
   int m_state, m_pend, m_ovf, m_cnt, m_vs_prev, m_tick, m_ins, m_dec, m_sr;

   game_score_controller #(.SERVE_FRAMES(SF), .MAX_PENDING(MP)) dut (
      .clk(clk), .reset(reset), .start(start), .vsync(vsync),
      .brick_hit(brick_hit), .ball_lost(ball_lost), .lives_in(lives_in),
      .inscore(inscore), .declives(declives), .stats_reset(stats_reset),
      .ball_enable(ball_enable), .state(state), .pending(pending),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = S_ATTRACT; m_pend = 0; m_ovf = 0; m_cnt = 0;
      m_vs_prev = 0; m_tick = 0; m_ins = 0; m_dec = 0; m_sr = 0;
   endtask

   // Apply the game rules for one rising edge using the inputs just driven.
   task automatic model_edge();
      int tick, hit, drn;
      tick = m_tick;
      m_tick = (vsync && m_vs_prev == 0) ? 1 : 0;
      m_vs_prev = vsync ? 1 : 0;
      m_ins = 0; m_dec = 0; m_sr = 0;
      if ((m_state == S_ATTRACT || m_state == S_OVER) && start) begin
         m_sr = 1; m_pend = 0; m_ovf = 0; m_cnt = SF; m_state = S_SERVE;
      end else begin
         drn = (tick != 0 && m_state != S_ATTRACT && m_pend > 0) ? 1 : 0;
         hit = (m_state == S_PLAY && brick_hit) ? 1 : 0;
         if (hit != 0 && m_pend >= MP) begin
            m_ovf = 1;
            hit = 0;
         end
         m_pend = m_pend + hit - drn;
         m_ins = drn;
         case (m_state)
            S_SERVE: if (tick != 0) begin
               m_cnt = m_cnt - 1;
               if (m_cnt == 0) m_state = S_PLAY;
            end
            S_PLAY: if (ball_lost) begin
               m_dec = 1;
               m_state = S_LOSE;
            end
            S_LOSE: if (tick != 0) begin
               if (lives_in == 0) m_state = S_OVER;
               else begin
                  m_cnt = SF;
                  m_state = S_SERVE;
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic compare_all();
      check("state", int'(state), m_state);
      check("pending", int'(pending), m_pend);
      check("overflow", int'(overflow), m_ovf);
      check("inscore", int'(inscore), m_ins);
      check("declives", int'(declives), m_dec);
      check("stats_reset", int'(stats_reset), m_sr);
      check("ball_enable", int'(ball_enable), (m_state == S_PLAY) ? 1 : 0);
      if (inscore) ins_seen++;
   endtask

   task automatic step(input logic s, input logic v, input logic h, input logic l);
      @(negedge clk);
      start = s; vsync = v; brick_hit = h; ball_lost = l;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         step(0, 1, 0, 0);
         step(0, 0, 0, 0);
         step(0, 0, 0, 0);
      end
   endtask

   // Reset asserted between clock edges; outputs must clear at once.
   task automatic async_reset();
      @(negedge clk);
      start = 0; vsync = 0; brick_hit = 0; ball_lost = 0;
      #2 reset = 1'b1;
      model_reset();
      #1;
      compare_all();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int ins_before;
      model_reset();

      // reset state
      async_reset();
      check("rst_state", int'(state), S_ATTRACT);

      // start a game, serve for SF frames
      step(1, 0, 0, 0);
      check("start_sr", int'(stats_reset), 1);
      check("start_state", int'(state), S_SERVE);
      frames(SF - 1);
      check("serve_59", int'(state), S_SERVE);
      frames(1);
      check("serve_done", int'(state), S_PLAY);
      check("ball_en", int'(ball_enable), 1);

      // three hits, three drains, then nothing
      step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
      check("pend3", int'(pending), 3);
      ins_before = ins_seen;
      frames(3);
      check("ins3", ins_seen - ins_before, 3);
      check("pend0", int'(pending), 0);
      frames(1);
      check("ins_none", ins_seen - ins_before, 3);

      // saturation and hit coincident with drain at the limit
      for (int i = 0; i < 20; i++) step(0, 0, 1, 0);
      check("sat_pend", int'(pending), MP);
      check("sat_ovf", int'(overflow), 1);
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      check("sat_drain", int'(pending), MP - 1);

      // lose a ball with lives left
      lives_in = 4'd2;
      step(0, 0, 0, 1);
      check("lose_dec", int'(declives), 1);
      check("lose_state", int'(state), S_LOSE);
      step(0, 0, 0, 0);
      check("dec_once", int'(declives), 0);
      frames(1);
      check("reserve", int'(state), S_SERVE);
      frames(SF);
      check("replay", int'(state), S_PLAY);

      // last ball: hit and loss in the same clk
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
      lives_in = 4'd0;
      step(0, 0, 1, 1);
      check("both_pend", int'(pending), 6);
      check("both_state", int'(state), S_LOSE);
      frames(1);
      check("over", int'(state), S_OVER);
      check("over_ben", int'(ball_enable), 0);
      check("over_pend", int'(pending), 5);

      // restart from OVER with points queued, coincident with a frame tick
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      check("rs_sr", int'(stats_reset), 1);
      check("rs_pend", int'(pending), 0);
      check("rs_ins", int'(inscore), 0);
      check("rs_ovf", int'(overflow), 0);
      check("rs_state", int'(state), S_SERVE);
      step(0, 0, 0, 0);
      check("sr_once", int'(stats_reset), 0);

      // reset mid-game with points queued
      lives_in = 4'd3;
      frames(SF);
      for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
      check("pend7", int'(pending), 7);
      async_reset();
      check("mid_state", int'(state), S_ATTRACT);
      check("mid_pend", int'(pending), 0);
      ins_before = ins_seen;
      frames(4);
      check("mid_noins", ins_seen - ins_before, 0);

      // randomized play
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 999) == 0) begin
            async_reset();
         end else begin
            lives_in = 4'($urandom_range(0, 2));
            step(($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 39) == 0));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
